aurora_tx_lane_ctrl: RTL and testbench



---
 rtl/aurora_pkg.sv | 40 ++++
 rtl/aurora_cc_scheduler.sv | 67 ++++++
 rtl/aurora_tx_lane_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_aurora_tx_lane_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aurora_pkg.sv
// Shared Aurora TX types: lane geometry, encoder block commands, channel-controller states.
// Also provides the lane-enable mask helper used by the TX lane controller.
package aurora_pkg;

  localparam int MAX_LINKS      = 4;
  localparam int MAX_LINKS_SIZE = $clog2(MAX_LINKS);

  typedef enum logic [2:0] {
    TX_OFF     = 3'd0,
    TX_IDLE_NR = 3'd1,
    TX_IDLE    = 3'd2,
    TX_CC      = 3'd3,
    TX_DATA    = 3'd4
  } tx_cmd_t;

  typedef enum logic [2:0] {
    RESET  = 3'd0,
    ALIGN  = 3'd1,
    BOND   = 3'd2,
    VERIFY = 3'd3,
    READY  = 3'd4
  } ctrl_state_t;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Single-lane: one-hot of the selected lane; multi-lane: every lane enabled.
  function automatic logic [MAX_LINKS-1:0] lane_mask(input logic single,
                                                     input logic [MAX_LINKS_SIZE-1:0] sel);
    logic [MAX_LINKS-1:0] m;
    if (single) begin
      m = {{(MAX_LINKS-1){1'b0}}, 1'b1} << sel;
    end else begin
      m = {MAX_LINKS{1'b1}};
    end
    return m;
  endfunction

endpackage

// File: rtl/aurora_cc_scheduler.sv
// Clock-compensation scheduler: period and length counters for CC insertion while READY.
// cc_active reports whether the upcoming cycle is a CC cycle, so the parent can register it.
module aurora_cc_scheduler #(
  parameter int CC_PERIOD = 5000,
  parameter int CC_LEN    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic cc_active
);

  localparam int CNT_W = $clog2(CC_PERIOD + 1);
  localparam int LEN_W = $clog2(CC_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CC_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [LEN_W-1:0] LEN_M1   = LEN_W'(CC_LEN - 1);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [LEN_W-1:0] rem_r, rem_s;
  logic             running_r;
  logic             cc_s;

  // Next-cycle counter values; the first READY cycle always starts at count 0.
  always_comb begin
    cnt_s = {CNT_W{1'b0}};
    rem_s = {LEN_W{1'b0}};
    cc_s  = 1'b0;
    if (enable && running_r) begin
      if (cnt_r == CNT_LAST) begin
        cnt_s = {CNT_W{1'b0}};
        rem_s = LEN_M1;
        cc_s  = 1'b1;
      end else begin
        cnt_s = cnt_r + CNT_ONE;
        if (rem_r != {LEN_W{1'b0}}) begin
          rem_s = rem_r - LEN_ONE;
          cc_s  = 1'b1;
        end else begin
          rem_s = {LEN_W{1'b0}};
          cc_s  = 1'b0;
        end
      end
    end else begin
      cnt_s = {CNT_W{1'b0}};
      rem_s = {LEN_W{1'b0}};
      cc_s  = 1'b0;
    end
  end

  // Counter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r     <= {CNT_W{1'b0}};
      rem_r     <= {LEN_W{1'b0}};
      running_r <= 1'b0;
    end else begin
      cnt_r     <= cnt_s;
      rem_r     <= rem_s;
      running_r <= enable;
    end
  end

  assign cc_active = cc_s;

endmodule

// File: rtl/aurora_tx_lane_ctrl.sv
// Aurora simplex TX channel controller: init sequencing, lane selection, CC scheduling.
// Optional macro AURORA_SIMPLEX_TIMER_EN replaces sideband progress and watchdog with fixed timers.
module aurora_tx_lane_ctrl
  import aurora_pkg::*;
#(
  parameter int RESET_CYCLES    = 16,
  parameter int WATCHDOG_CYCLES = 4096,
  parameter int CC_PERIOD       = 5000,
  parameter int CC_LEN          = 3,
  parameter int ALIGN_CYCLES    = 64,
  parameter int BOND_CYCLES     = 64,
  parameter int VERIFY_CYCLES   = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      single_lane,
  input  logic [MAX_LINKS_SIZE-1:0] lane_select,
  input  logic                      axi_valid,
  input  logic                      simplex_aligned,
  input  logic                      simplex_bonded,
  input  logic                      simplex_verified,
  input  logic                      simplex_reset,
  output logic                      axi_ready,
  output logic [MAX_LINKS-1:0]      lane_en,
  output tx_cmd_t                   tx_cmd,
  output logic                      channel_up,
  output logic                      err_timeout,
  output ctrl_state_t               ctrl_state
);

  localparam int CNT_MAX = max_of(max_of(RESET_CYCLES, WATCHDOG_CYCLES),
                                  max_of(ALIGN_CYCLES, max_of(BOND_CYCLES, VERIFY_CYCLES)));
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(RESET_CYCLES - 1);

  ctrl_state_t                state_r, state_s;
  logic [CNT_W-1:0]           cnt_r, cnt_s;
  logic                       single_r, single_s;
  logic [MAX_LINKS_SIZE-1:0]  sel_r, sel_s;
  logic                       timeout_s, cc_s;
  logic                       go_align_s, go_bond_s, go_verify_s, wd_exp_s;
  logic [MAX_LINKS-1:0]       lane_s;
  tx_cmd_t                    tx_s;

`ifdef AURORA_SIMPLEX_TIMER_EN
  localparam logic [CNT_W-1:0] ALIGN_LAST  = CNT_W'(ALIGN_CYCLES - 1);
  localparam logic [CNT_W-1:0] BOND_LAST   = CNT_W'(BOND_CYCLES - 1);
  localparam logic [CNT_W-1:0] VERIFY_LAST = CNT_W'(VERIFY_CYCLES - 1);
  logic unused_s;
  assign unused_s    = &{1'b0, simplex_aligned, simplex_bonded, simplex_verified};
  assign go_align_s  = (cnt_r == ALIGN_LAST);
  assign go_bond_s   = (cnt_r == BOND_LAST);
  assign go_verify_s = (cnt_r == VERIFY_LAST);
  assign wd_exp_s    = 1'b0;
`else
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WATCHDOG_CYCLES - 1);
  assign go_align_s  = simplex_aligned;
  assign go_bond_s   = simplex_bonded;
  assign go_verify_s = simplex_verified;
  assign wd_exp_s    = (cnt_r == WD_LAST);
`endif

  aurora_cc_scheduler #(
    .CC_PERIOD (CC_PERIOD),
    .CC_LEN    (CC_LEN)
  ) u_cc (
    .clk       (clk),
    .rst       (rst),
    .enable    (state_s == READY),
    .cc_active (cc_s)
  );

  // Next state; sideband reset outranks the watchdog, which outranks progress inputs.
  always_comb begin
    state_s   = state_r;
    timeout_s = 1'b0;
    if ((state_r != RESET) && simplex_reset) begin
      state_s   = RESET;
      timeout_s = 1'b0;
    end else begin
      case (state_r)
        RESET:   state_s = (cnt_r == RESET_LAST) ? ALIGN : RESET;
        ALIGN: begin
          if (wd_exp_s) begin
            state_s   = RESET;
            timeout_s = 1'b1;
          end else if (go_align_s) begin
            state_s = single_r ? VERIFY : BOND;
          end else begin
            state_s = ALIGN;
          end
        end
        BOND: begin
          if (wd_exp_s) begin
            state_s   = RESET;
            timeout_s = 1'b1;
          end else if (go_bond_s) begin
            state_s = VERIFY;
          end else begin
            state_s = BOND;
          end
        end
        VERIFY: begin
          if (wd_exp_s) begin
            state_s   = RESET;
            timeout_s = 1'b1;
          end else if (go_verify_s) begin
            state_s = READY;
          end else begin
            state_s = VERIFY;
          end
        end
        READY:   state_s = READY;
        default: state_s = RESET;
      endcase
    end
  end

  // Lane config latch, phase counter and the registered-output values for the next cycle.
  always_comb begin
    single_s = single_r;
    sel_s    = sel_r;
    if ((state_r == RESET) && (state_s == ALIGN)) begin
      single_s = single_lane;
      sel_s    = lane_select;
    end else begin
      single_s = single_r;
      sel_s    = sel_r;
    end
    if ((state_s != state_r) || (state_s == READY)) begin
      cnt_s = {CNT_W{1'b0}};
    end else begin
      cnt_s = cnt_r + CNT_ONE;
    end
    lane_s = (state_s == RESET) ? {MAX_LINKS{1'b0}} : lane_mask(single_s, sel_s);
    case (state_s)
      RESET:       tx_s = TX_OFF;
      ALIGN, BOND: tx_s = TX_IDLE_NR;
      VERIFY:      tx_s = TX_IDLE;
      READY: begin
        if (cc_s) begin
          tx_s = TX_CC;
        end else if (axi_valid) begin
          tx_s = TX_DATA;
        end else begin
          tx_s = TX_IDLE;
        end
      end
      default:     tx_s = TX_OFF;
    endcase
  end

  // State, counter, latch and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= RESET;
      cnt_r       <= {CNT_W{1'b0}};
      single_r    <= 1'b0;
      sel_r       <= {MAX_LINKS_SIZE{1'b0}};
      axi_ready   <= 1'b0;
      lane_en     <= {MAX_LINKS{1'b0}};
      tx_cmd      <= TX_OFF;
      channel_up  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      single_r    <= single_s;
      sel_r       <= sel_s;
      axi_ready   <= (state_s == READY) && !cc_s;
      lane_en     <= lane_s;
      tx_cmd      <= tx_s;
      channel_up  <= (state_s == READY);
      err_timeout <= timeout_s;
    end
  end

  assign ctrl_state = state_r;

endmodule

// File: tb/tb_aurora_tx_lane_ctrl.sv
// Scoreboard bench for aurora_tx_lane_ctrl: expectations are queued per cycle as stimulus is scheduled.
// Build with AURORA_SIMPLEX_TIMER_EN to exercise the timer-driven sequencing.
module tb_aurora_tx_lane_ctrl;
  import aurora_pkg::*;

  localparam int RST_C = 16;
  localparam int WD_C  = 50;
  localparam int CCP   = 20;
  localparam int CCL   = 3;
  localparam int PH_C  = 8;

  localparam int S_STATE = 0;
  localparam int S_LANE  = 1;
  localparam int S_TX    = 2;
  localparam int S_UP    = 3;
  localparam int S_RDY   = 4;
  localparam int S_TO    = 5;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      single_lane = 1'b0;
  logic [MAX_LINKS_SIZE-1:0] lane_select = '0;
  logic                      axi_valid = 1'b0;
  logic                      simplex_aligned = 1'b0;
  logic                      simplex_bonded = 1'b0;
  logic                      simplex_verified = 1'b0;
  logic                      simplex_reset = 1'b0;
  logic                      axi_ready;
  logic [MAX_LINKS-1:0]      lane_en;
  tx_cmd_t                   tx_cmd;
  logic                      channel_up;
  logic                      err_timeout;
  ctrl_state_t               ctrl_state;

  aurora_tx_lane_ctrl #(
    .RESET_CYCLES    (RST_C),
    .WATCHDOG_CYCLES (WD_C),
    .CC_PERIOD       (CCP),
    .CC_LEN          (CCL),
    .ALIGN_CYCLES    (PH_C),
    .BOND_CYCLES     (PH_C),
    .VERIFY_CYCLES   (PH_C)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .single_lane      (single_lane),
    .lane_select      (lane_select),
    .axi_valid        (axi_valid),
    .simplex_aligned  (simplex_aligned),
    .simplex_bonded   (simplex_bonded),
    .simplex_verified (simplex_verified),
    .simplex_reset    (simplex_reset),
    .axi_ready        (axi_ready),
    .lane_en          (lane_en),
    .tx_cmd           (tx_cmd),
    .channel_up       (channel_up),
    .err_timeout      (err_timeout),
    .ctrl_state       (ctrl_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int sig;
    int val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic string sig_name(input int sig);
    case (sig)
      S_STATE: return "ctrl_state";
      S_LANE:  return "lane_en";
      S_TX:    return "tx_cmd";
      S_UP:    return "channel_up";
      S_RDY:   return "axi_ready";
      S_TO:    return "err_timeout";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [31:0] obs_of(input int sig);
    logic [31:0] v;
    case (sig)
      S_STATE: v = 32'(ctrl_state);
      S_LANE:  v = 32'(lane_en);
      S_TX:    v = 32'(tx_cmd);
      S_UP:    v = 32'(channel_up);
      S_RDY:   v = 32'(axi_ready);
      S_TO:    v = 32'(err_timeout);
      default: v = 32'hDEAD_BEEF;
    endcase
    return v;
  endfunction

  task automatic exp_at(input int c, input int sig, input int val);
    exp_t e;
    e.cyc = c;
    e.sig = sig;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic exp_all(input int c, input int st, input int ln, input int tx,
                         input int up, input int rdy, input int to);
    exp_at(c, S_STATE, st);
    exp_at(c, S_LANE, ln);
    exp_at(c, S_TX, tx);
    exp_at(c, S_UP, up);
    exp_at(c, S_RDY, rdy);
    exp_at(c, S_TO, to);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Compare every expectation due this cycle, mid-cycle, and retire it.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check_eq($sformatf("%s@%0d", sig_name(sb[i].sig), cyc), obs_of(sb[i].sig), sb[i].val);
        sb.delete(i);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL tb_timeout: simulation did not finish, got cycle %0d expected end", cyc);
    $fatal(1);
  end

  initial begin
    int r0, a2, e0, a3;
    bit cc;
`ifdef AURORA_SIMPLEX_TIMER_EN
    single_lane = 1'b0;
    lane_select = 2'd0;
    wait_cyc(2);
    rst = 1'b0;
    r0 = 2;
    exp_all(r0, RESET, 4'b0000, TX_OFF, 0, 0, 0);
    exp_all(r0 + 15, RESET, 4'b0000, TX_OFF, 0, 0, 0);
    exp_all(r0 + 16, ALIGN, 4'b1111, TX_IDLE_NR, 0, 0, 0);
    exp_at(r0 + 23, S_STATE, ALIGN);
    exp_all(r0 + 24, BOND, 4'b1111, TX_IDLE_NR, 0, 0, 0);
    exp_at(r0 + 31, S_STATE, BOND);
    exp_all(r0 + 32, VERIFY, 4'b1111, TX_IDLE, 0, 0, 0);
    exp_at(r0 + 39, S_STATE, VERIFY);
    exp_at(r0 + 39, S_UP, 0);
    exp_all(r0 + RST_C + 24, READY, 4'b1111, TX_IDLE, 1, 1, 0);
    exp_all(r0 + 46, RESET, 4'b0000, TX_OFF, 0, 0, 0);
    exp_at(r0 + 62, S_STATE, ALIGN);
    for (int k = 1; k <= 66; k++) begin
      if (k != 40 && k != 46) exp_at(r0 + k, S_TO, 0);
    end
    wait_cyc(r0 + 45);
    simplex_reset = 1'b1;
    wait_cyc(r0 + 46);
    simplex_reset = 1'b0;
    wait_cyc(r0 + 70);
`else
    // Single lane on lane 2: BOND skipped, bonded pulse ignored.
    single_lane = 1'b1;
    lane_select = 2'd2;
    wait_cyc(2);
    rst = 1'b0;
    r0 = 2;
    exp_all(r0, RESET, 4'b0000, TX_OFF, 0, 0, 0);
    exp_all(r0 + 15, RESET, 4'b0000, TX_OFF, 0, 0, 0);
    exp_all(r0 + 16, ALIGN, 4'b0100, TX_IDLE_NR, 0, 0, 0);
    exp_at(r0 + 20, S_STATE, ALIGN);
    exp_all(r0 + 21, VERIFY, 4'b0100, TX_IDLE, 0, 0, 0);
    exp_at(r0 + 26, S_STATE, VERIFY);
    exp_at(r0 + 30, S_UP, 0);
    exp_all(r0 + 31, READY, 4'b0100, TX_IDLE, 1, 1, 0);
    exp_at(r0 + 35, S_TX, TX_DATA);
    exp_at(r0 + 36, S_LANE, 4'b0100);
    exp_at(r0 + 40, S_LANE, 4'b0100);
    exp_all(r0 + 41, RESET, 4'b0000, TX_OFF, 0, 0, 0);
    wait_cyc(r0 + 20); simplex_aligned = 1'b1;
    wait_cyc(r0 + 21); simplex_aligned = 1'b0;
    wait_cyc(r0 + 25); simplex_bonded = 1'b1;
    wait_cyc(r0 + 26); simplex_bonded = 1'b0;
    wait_cyc(r0 + 30); simplex_verified = 1'b1;
    wait_cyc(r0 + 31); simplex_verified = 1'b0;
    // Lane config change while READY must not reach lane_en before the next RESET.
    wait_cyc(r0 + 33);
    single_lane = 1'b0;
    lane_select = 2'd1;
    axi_valid   = 1'b1;
    wait_cyc(r0 + 40); simplex_reset = 1'b1;
    wait_cyc(r0 + 41); simplex_reset = 1'b0;

    // Multi-lane re-sequence, then CC scheduling with axi_valid held high.
    a2 = r0 + 41 + RST_C;
    e0 = a2 + 13;
    exp_all(a2, ALIGN, 4'b1111, TX_IDLE_NR, 0, 0, 0);
    exp_all(a2 + 4, BOND, 4'b1111, TX_IDLE_NR, 0, 0, 0);
    exp_all(a2 + 9, VERIFY, 4'b1111, TX_IDLE, 0, 0, 0);
    exp_at(e0 - 1, S_UP, 0);
    exp_at(e0, S_STATE, READY);
    exp_at(e0, S_UP, 1);
    exp_at(e0, S_LANE, 4'b1111);
    for (int k = 0; k <= 40; k++) begin
      cc = (k >= CCP && k < CCP + CCL) || (k >= 2 * CCP && k < 2 * CCP + CCL);
      exp_at(e0 + k, S_RDY, cc ? 0 : 1);
      exp_at(e0 + k, S_TX, cc ? TX_CC : TX_DATA);
    end
    exp_all(e0 + 41, RESET, 4'b0000, TX_OFF, 0, 0, 0);
    wait_cyc(a2 + 3);  simplex_aligned = 1'b1;
    wait_cyc(a2 + 4);  simplex_aligned = 1'b0;
    wait_cyc(a2 + 8);  simplex_bonded = 1'b1;
    wait_cyc(a2 + 9);  simplex_bonded = 1'b0;
    wait_cyc(a2 + 12); simplex_verified = 1'b1;
    wait_cyc(a2 + 13); simplex_verified = 1'b0;
    wait_cyc(e0 + 40); simplex_reset = 1'b1;
    wait_cyc(e0 + 41); simplex_reset = 1'b0;

    // Watchdog in ALIGN; an aligned pulse in the expiry cycle must lose.
    a3 = e0 + 41 + RST_C;
    exp_at(a3, S_STATE, ALIGN);
    exp_at(a3 + WD_C - 1, S_STATE, ALIGN);
    exp_at(a3 + WD_C - 1, S_TO, 0);
    exp_all(a3 + WD_C, RESET, 4'b0000, TX_OFF, 0, 0, 1);
    exp_at(a3 + WD_C + 1, S_TO, 0);
    exp_at(a3 + WD_C + RST_C, S_STATE, ALIGN);
    wait_cyc(a3 + WD_C - 1); simplex_aligned = 1'b1;
    wait_cyc(a3 + WD_C);     simplex_aligned = 1'b0;
    wait_cyc(a3 + WD_C + RST_C + 4);
`endif
    check_eq("sb_drain", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
